button_debouncer: RTL



---
 rtl/button_debouncer_pkg.sv | 17 +
 rtl/sync_2ff.sv | 24 ++
 rtl/button_debouncer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared types for the push-button conditioner: FSM state encoding and the
// helper that yields the idle (released) pin level for a given polarity.
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // Raw pin level while the button is not pressed.
    function automatic logic released_level(input int active_low);
        return (active_low != 0);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous bit; the reset value
// lets the chain start at the input's idle level so no false edge is seen.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= {2{RESET_VALUE}};
        end else begin
            sync_reg <= {sync_reg[0], d};
        end
    end

    assign q = sync_reg[1];

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronise, debounce, emit level plus press/release/long pulses.
// Define BUTTON_DEBOUNCER_PRESS_COUNT_EN to add the 8-bit wrapping o_press_count output.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONG_CYCLES     = 256,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_button_raw,
    output logic       o_level,
    output logic       o_press,
    output logic       o_release,
`ifdef BUTTON_DEBOUNCER_PRESS_COUNT_EN
    output logic       o_long,
    output logic [7:0] o_press_count
`else
    output logic       o_long
`endif
);

    localparam int              DW         = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int              HW         = $clog2(LONG_CYCLES) + 1;
    localparam logic [DW-1:0]   D_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0]   H_LAST     = HW'(LONG_CYCLES - 1);
    localparam logic            REL_LEVEL  = released_level(ACTIVE_LOW);

    logic          sync_q;
    logic          btn;
    state_t        state_reg;
    logic [DW-1:0] dcnt_reg;
    logic [HW-1:0] hcnt_reg;
    logic [HW-1:0] hcnt_next;
    logic          long_done_reg;
    logic          long_hit;

    sync_2ff #(
        .RESET_VALUE (REL_LEVEL)
    ) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (i_button_raw),
        .q     (sync_q)
    );

    assign btn       = sync_q ^ REL_LEVEL;
    assign hcnt_next = (hcnt_reg == H_LAST) ? hcnt_reg : hcnt_reg + 1'b1;
    // Long fires on the edge the hold count reaches its last value, once per press.
    assign long_hit  = (hcnt_next == H_LAST) && !long_done_reg;

`ifdef BUTTON_DEBOUNCER_PRESS_COUNT_EN
    logic [7:0] press_count_reg;
    assign o_press_count = press_count_reg;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= RELEASED;
            dcnt_reg      <= '0;
            hcnt_reg      <= '0;
            long_done_reg <= 1'b0;
            o_level       <= 1'b0;
            o_press       <= 1'b0;
            o_release     <= 1'b0;
            o_long        <= 1'b0;
`ifdef BUTTON_DEBOUNCER_PRESS_COUNT_EN
            press_count_reg <= '0;
`endif
        end else begin
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= 1'b0;
            case (state_reg)
                RELEASED: begin
                    if (btn) begin
                        state_reg <= PRESS_WAIT;
                        dcnt_reg  <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn) begin
                        state_reg <= RELEASED;
                        dcnt_reg  <= '0;
                    end else if (dcnt_reg == D_LAST) begin
                        state_reg     <= PRESSED;
                        o_level       <= 1'b1;
                        o_press       <= 1'b1;
                        hcnt_reg      <= '0;
                        long_done_reg <= 1'b0;
`ifdef BUTTON_DEBOUNCER_PRESS_COUNT_EN
                        press_count_reg <= press_count_reg + 8'd1;
`endif
                    end else begin
                        dcnt_reg <= dcnt_reg + 1'b1;
                    end
                end
                PRESSED: begin
                    hcnt_reg <= hcnt_next;
                    if (long_hit) begin
                        o_long        <= 1'b1;
                        long_done_reg <= 1'b1;
                    end
                    if (!btn) begin
                        state_reg <= RELEASE_WAIT;
                        dcnt_reg  <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    hcnt_reg <= hcnt_next;
                    if (!btn && dcnt_reg == D_LAST) begin
                        // Release wins: a long pulse never shares a cycle with o_release.
                        state_reg <= RELEASED;
                        o_level   <= 1'b0;
                        o_release <= 1'b1;
                    end else begin
                        if (long_hit) begin
                            o_long        <= 1'b1;
                            long_done_reg <= 1'b1;
                        end
                        if (btn) begin
                            state_reg <= PRESSED;
                        end else begin
                            dcnt_reg <= dcnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= RELEASED;
                end
            endcase
        end
    end

endmodule
